panda_divider: RTL and testbench

PANDA_DIVIDER -- requirements
Module: panda_divider

---
 rtl/panda_divider.sv | 215 +++++++++++++++++++++
 tb/tb_panda_divider.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_divider.sv
// -----------------------------------------------------------------------------
// panda_divider
//   Multi-cycle restoring radix-2 integer divider with a valid/ready handshake
//   on both the request and the result side. It runs on absolute values,
//   performs one quotient bit per DIVIDE cycle for exactly Width cycles, and
//   uses one final cycle to apply sign correction and select the output. The
//   latency is therefore Width+1 edges from accept to valid_o, whatever the
//   operand values.
//
// Ports
//   clk_i        in   1      clock, rising edge
//   rst_i        in   1      synchronous active-high reset
//   valid_i      in   1      request valid
//   ready_o      out  1      divider idle, request can be accepted
//   operand_a_i  in   Width  dividend
//   operand_b_i  in   Width  divisor
//   signed_i     in   1      1 = two's-complement operands
//   rem_i        in   1      1 = return remainder, 0 = quotient
//   kill_i       in   1      abort in-flight operation (DIVIDE / DONE)
//   valid_o      out  1      result valid
//   ready_i      in   1      consumer accepts result
//   result_o     out  Width  quotient or remainder, zero while not valid
// -----------------------------------------------------------------------------
module panda_divider #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic             signed_i,
    input  logic             rem_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o
);

    localparam int CntW = $clog2(Width + 1);
    // Counter value on the sign-fixup cycle that follows the last iteration.
    localparam logic [CntW-1:0] LastCnt = CntW'(Width);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Two's-complement negation when neg is set, pass-through otherwise.
    // The most negative value maps onto itself, which is also its correct
    // unsigned magnitude.
    function automatic logic [Width-1:0] cond_negate(input logic [Width-1:0] v,
                                                     input logic             neg);
        logic [Width-1:0] res;
        if (neg) begin
            res = ~v + {{(Width-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CntW-1:0]  cnt_r;
    logic [Width-1:0] quo_r;       // dividend magnitude shifting out, quotient bits shifting in
    logic [Width-1:0] rem_r;       // partial remainder
    logic [Width-1:0] div_r;       // divisor magnitude
    logic             neg_q_r;
    logic             neg_r_r;
    logic             div_zero_r;
    logic             rem_sel_r;
    logic             ready_r;
    logic             valid_r;
    logic [Width-1:0] result_r;

    logic [Width:0]   shifted_s;
    logic [Width:0]   diff_s;
    logic [Width-1:0] quo_step_s;
    logic [Width-1:0] rem_step_s;
    logic [Width-1:0] quo_fix_s;
    logic [Width-1:0] rem_fix_s;
    logic [Width-1:0] result_fix_s;

    // Next-state decode; kill_i overrides both completion and consumption.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_i) begin
                    state_nxt_s = DIVIDE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DIVIDE: begin
                if (kill_i) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == LastCnt) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DIVIDE;
                end
            end
            DONE: begin
                if (kill_i || ready_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted_s  = {rem_r, quo_r[Width-1]};
        diff_s     = shifted_s - {1'b0, div_r};
        quo_step_s = {quo_r[Width-2:0], ~diff_s[Width]};
        if (diff_s[Width]) begin
            rem_step_s = shifted_s[Width-1:0];
        end else begin
            rem_step_s = diff_s[Width-1:0];
        end
    end

    // Sign correction and output selection. A zero divisor leaves an all-ones
    // quotient magnitude, which is forced to stay all ones regardless of sign.
    always_comb begin
        rem_fix_s = cond_negate(rem_r, neg_r_r);
        if (div_zero_r) begin
            quo_fix_s = {Width{1'b1}};
        end else begin
            quo_fix_s = cond_negate(quo_r, neg_q_r);
        end
        if (rem_sel_r) begin
            result_fix_s = rem_fix_s;
        end else begin
            result_fix_s = quo_fix_s;
        end
    end

    // State register and registered handshake flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            valid_r <= (state_nxt_s == DONE);
        end
    end

    // Datapath: operand capture, iteration, fixup and result hold/clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r      <= {CntW{1'b0}};
            quo_r      <= {Width{1'b0}};
            rem_r      <= {Width{1'b0}};
            div_r      <= {Width{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
            rem_sel_r  <= 1'b0;
            result_r   <= {Width{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        cnt_r      <= {CntW{1'b0}};
                        quo_r      <= cond_negate(operand_a_i, signed_i & operand_a_i[Width-1]);
                        div_r      <= cond_negate(operand_b_i, signed_i & operand_b_i[Width-1]);
                        rem_r      <= {Width{1'b0}};
                        neg_q_r    <= signed_i & (operand_a_i[Width-1] ^ operand_b_i[Width-1]);
                        neg_r_r    <= signed_i & operand_a_i[Width-1];
                        div_zero_r <= (operand_b_i == {Width{1'b0}});
                        rem_sel_r  <= rem_i;
                    end
                    result_r <= {Width{1'b0}};
                end
                DIVIDE: begin
                    if (kill_i) begin
                        result_r <= {Width{1'b0}};
                    end else if (cnt_r == LastCnt) begin
                        result_r <= result_fix_s;
                    end else begin
                        quo_r <= quo_step_s;
                        rem_r <= rem_step_s;
                        cnt_r <= cnt_r + {{(CntW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (kill_i || ready_i) begin
                        result_r <= {Width{1'b0}};
                    end
                end
                default: begin
                    result_r <= {Width{1'b0}};
                end
            endcase
        end
    end

    assign ready_o  = ready_r;
    assign valid_o  = valid_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_panda_divider.sv
// -----------------------------------------------------------------------------
// tb_panda_divider
//   Self-checking bench for panda_divider (Width = 32): a table of directed
//   vectors, hand-written backpressure / kill / reset sequences, and a
//   randomized run against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_panda_divider;

    localparam int W = 32;
    localparam int Lat = W + 1;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] operand_a_i;
    logic [W-1:0] operand_b_i;
    logic         signed_i;
    logic         rem_i;
    logic         kill_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;

    int checks = 0;
    int errors = 0;

    panda_divider #(.Width(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .signed_i    (signed_i),
        .rem_i       (rem_i),
        .kill_i      (kill_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        r;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the documented special cases.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic r);
        longint sa, sb, q, m;
        if (b == 32'd0) begin
            return r ? a : 32'hFFFF_FFFF;
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;   // SV truncates toward zero, remainder takes dividend sign
        m = sa % sb;
        return r ? m[31:0] : q[31:0];
    endfunction

    task automatic scramble();
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        signed_i    = 1'($urandom_range(0, 1));
        rem_i       = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for ready_o, present a request, return at the negedge after accept.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic r);
        int n;
        @(negedge clk_i);
        n = 0;
        while (!ready_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        check("ready_before_accept", 64'(ready_o), 64'd1);
        operand_a_i = a;
        operand_b_i = b;
        signed_i    = s;
        rem_i       = r;
        valid_i     = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        scramble();
    endtask

    // Count edges from accept until valid_o, scrambling operands meanwhile.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
            scramble();
            if (valid_o) break;
        end
    endtask

    // Consume the result and check the handshake around it.
    task automatic consume();
        check("ready_low_in_done", 64'(ready_o), 64'd0);
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b0;
        check("valid_after_consume", 64'(valid_o), 64'd0);
        check("result_zero_after_consume", 64'(result_o), 64'd0);
        check("ready_after_consume", 64'(ready_o), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic r, input logic [31:0] exp);
        int lat;
        start_op(a, b, s, r);
        wait_done(lat);
        check({name, "_latency"}, 64'(lat), 64'(Lat));
        check(name, 64'(result_o), 64'(exp));
        consume();
    endtask

    initial begin
        int lat;
        int bad;
        logic [31:0] res0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        rr;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 1'b0, 32'd14};
        vecs[1]  = '{32'd100,        32'd7,          1'b0, 1'b1, 32'd2};
        vecs[2]  = '{-32'sd45,       32'd7,          1'b1, 1'b0, -32'sd6};
        vecs[3]  = '{-32'sd45,       32'd7,          1'b1, 1'b1, -32'sd3};
        vecs[4]  = '{32'd45,         -32'sd7,        1'b1, 1'b0, -32'sd6};
        vecs[5]  = '{32'd45,         -32'sd7,        1'b1, 1'b1, 32'd3};
        vecs[6]  = '{32'd12,         32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF};
        vecs[7]  = '{32'd12,         32'd0,          1'b0, 1'b1, 32'd12};
        vecs[8]  = '{-32'sd12,       32'd0,          1'b1, 1'b1, -32'sd12};
        vecs[9]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000};
        vecs[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0};
        vecs[11] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000};

        rst_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
        operand_a_i = 32'd0; operand_b_i = 32'd0; signed_i = 1'b0; rem_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("reset_ready", 64'(ready_o), 64'd1);
        check("reset_valid", 64'(valid_o), 64'd0);
        check("reset_result", 64'(result_o), 64'd0);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].exp);
        end

        // Backpressure: hold in DONE for 5 cycles while operands toggle.
        start_op(32'd1000, 32'd9, 1'b0, 1'b0);
        wait_done(lat);
        check("bp_latency", 64'(lat), 64'(Lat));
        res0 = result_o;
        check("bp_result", 64'(res0), 64'd111);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            scramble();
            if (!valid_o || result_o !== res0) bad++;
        end
        check("bp_stable", 64'(bad), 64'd0);
        consume();

        // Kill around iteration 10: no valid pulse, then a clean request.
        start_op(32'd1234567, 32'd3, 1'b0, 1'b0);
        repeat (9) @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b0;
        check("kill_ready", 64'(ready_o), 64'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) bad++;
            @(negedge clk_i);
        end
        check("kill_no_valid", 64'(bad), 64'd0);
        run_op("after_kill", 32'd35, 32'd5, 1'b0, 1'b0, 32'd7);

        // Kill beats ready_i in DONE.
        start_op(32'd77, 32'd7, 1'b0, 1'b0);
        wait_done(lat);
        check("killdone_valid_before", 64'(valid_o), 64'd1);
        kill_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b0;
        ready_i = 1'b0;
        check("killdone_valid", 64'(valid_o), 64'd0);
        check("killdone_result", 64'(result_o), 64'd0);
        check("killdone_ready", 64'(ready_o), 64'd1);

        // kill_i in IDLE does not block acceptance.
        kill_i = 1'b1;
        start_op(32'd90, 32'd4, 1'b0, 1'b1);
        kill_i = 1'b0;
        check("idle_kill_accepted", 64'(ready_o), 64'd0);
        wait_done(lat);
        check("idle_kill_latency", 64'(lat), 64'(Lat));
        check("idle_kill_result", 64'(result_o), 64'd2);
        consume();

        // Reset around iteration 20.
        start_op(32'd999, 32'd10, 1'b0, 1'b0);
        repeat (19) @(negedge clk_i);
        rst_i = 1'b1;
        kill_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        kill_i = 1'b0;
        check("rst_mid_valid", 64'(valid_o), 64'd0);
        check("rst_mid_ready", 64'(ready_o), 64'd1);
        check("rst_mid_result", 64'(result_o), 64'd0);
        run_op("after_rst", 32'd999, 32'd10, 1'b0, 1'b0, 32'd99);

        // Randomized against the reference model.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(0, 200));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                3:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            start_op(ra, rb, rs, rr);
            wait_done(lat);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(Lat));
            check($sformatf("rand%0d a=%0h b=%0h s=%0b r=%0b", i, ra, rb, rs, rr),
                  64'(result_o), 64'(ref_div(ra, rb, rs, rr)));
            ready_i = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            ready_i = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
